branch_cond_unit: RTL and testbench

- Parametrised, multi-cycle successor to the single-condition branch comparator.
- Evaluates all six RV32I branch conditions: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Compares the operands MSB-first in CHUNK-bit slices, one slice per cycle, and stops as soon as a slice differs. This trades latency for comparator area.
- Sits beside the ALU in the execute stage. It runs in parallel with the PC+imm adder and reports a registered taken/not-taken result with a start/done handshake.

---
 rtl/branch_pkg.sv | 49 ++++
 rtl/branch_chunk_cmp.sv | 34 +++
 rtl/branch_cond_unit.sv | 151 +++++++++++++++
 tb/tb_branch_cond_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared definitions for the branch condition unit: RV32I
//                branch funct3 codes, FSM state encoding and decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only 010 and 011 are unused branch encodings.
    function automatic logic is_valid(input logic [2:0] f3);
        return f3[2] | ~f3[1];
    endfunction

    // BLT/BGE compare two's-complement operands.
    function automatic logic is_signed(input logic [2:0] f3);
        return (f3[2:1] == 2'b10);
    endfunction

    // Map the final equality/less-than flags onto the branch decision.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt);
        logic taken;
        case (f3)
            F3_BEQ:           taken = eq;
            F3_BNE:           taken = ~eq;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = ~lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_chunk_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : branch_chunk_cmp
//  Description : Combinational CHUNK-bit slice comparator. For the top slice
//                of a signed compare the sign bits are flipped so an unsigned
//                comparison yields the two's-complement ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             signed_top,
    output logic             eq,
    output logic             lt
);

    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] w_flip;
    logic [CHUNK-1:0] w_a_adj;
    logic [CHUNK-1:0] w_b_adj;

    assign w_flip  = signed_top ? MSB_MASK : '0;
    assign w_a_adj = a ^ w_flip;
    assign w_b_adj = b ^ w_flip;

    // Flipping both MSBs does not change equality, only ordering.
    assign eq = (a == b);
    assign lt = (w_a_adj < w_b_adj);

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_unit
//  Description : Multi-cycle RV32I branch condition evaluator. Operands are
//                compared MSB-first one CHUNK-bit slice per cycle, stopping
//                at the first differing slice. Start/Done handshake with a
//                result that is held until the next Done.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    output logic             Busy,
    output logic             Done,
    output logic             BrRes,
    output logic             BrInvalid
);

    localparam int              NCHUNK  = WIDTH / CHUNK;
    localparam int              IDXW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_f3;
    logic [2:0]        r_res_op;
    logic              r_eq;
    logic              r_lt;
    logic              r_busy;
    logic              r_done;
    logic              r_invalid;

    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic              w_signed_top;
    logic              w_slice_eq;
    logic              w_slice_lt;

    // Select the slice currently addressed by the index counter.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_slice = r_a[i*CHUNK +: CHUNK];
                w_b_slice = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_signed_top = is_signed(r_f3) && (r_idx == IDX_TOP);

    branch_chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a          (w_a_slice),
        .b          (w_b_slice),
        .signed_top (w_signed_top),
        .eq         (w_slice_eq),
        .lt         (w_slice_lt)
    );

    // Control FSM: operand capture, slice walk and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_f3      <= F3_BEQ;
            r_res_op  <= F3_BEQ;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_a    <= RD1;
                        r_b    <= RD2;
                        r_f3   <= Funct3;
                        r_busy <= 1'b1;
                        if (is_valid(Funct3)) begin
                            r_idx   <= IDX_TOP;
                            r_state <= ST_CMP;
                        end else begin
                            // Invalid encodings report not-taken immediately;
                            // branch_taken() decodes them to 0.
                            r_res_op  <= Funct3;
                            r_eq      <= 1'b0;
                            r_lt      <= 1'b0;
                            r_invalid <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_CMP: begin
                    if (!w_slice_eq) begin
                        r_res_op  <= r_f3;
                        r_eq      <= 1'b0;
                        r_lt      <= w_slice_lt;
                        r_invalid <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (r_idx == '0) begin
                        r_res_op  <= r_f3;
                        r_eq      <= 1'b1;
                        r_lt      <= 1'b0;
                        r_invalid <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The decision is a pure function of registers that only change on the
    // edge raising Done, so it is stable until the next Done.
    assign BrRes     = branch_taken(r_res_op, r_eq, r_lt);
    assign BrInvalid = r_invalid;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_cond_unit
//  Description : Directed self-checking bench for branch_cond_unit, covering
//                the CHUNK=8 and CHUNK=32 configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start32;
    logic [2:0]  f3, f3_32;
    logic [31:0] rd1, rd2, rd1_32, rd2_32;
    logic        busy, done, brres, brinv;
    logic        busy32, done32, brres32, brinv32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .Start(start), .Funct3(f3), .RD1(rd1), .RD2(rd2),
        .Busy(busy), .Done(done), .BrRes(brres), .BrInvalid(brinv)
    );

    branch_cond_unit #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .Start(start32), .Funct3(f3_32), .RD1(rd1_32), .RD2(rd2_32),
        .Busy(busy32), .Done(done32), .BrRes(brres32), .BrInvalid(brinv32)
    );

    // Issue one operation; lat is the cycle offset of Done from the Start cycle (-1 on timeout).
    task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic res,
                          output logic inv);
        @(posedge clk); #1;
        if (sel) begin start32 = 1'b1; f3_32 = op; rd1_32 = a; rd2_32 = b; end
        else     begin start   = 1'b1; f3    = op; rd1    = a; rd2    = b; end
        @(posedge clk); #1;
        start = 1'b0; start32 = 1'b0;
        rd1 = $urandom; rd2 = $urandom; f3 = 3'($urandom);
        rd1_32 = $urandom; rd2_32 = $urandom; f3_32 = 3'($urandom);
        lat = 1;
        while (!(sel ? done32 : done) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(sel ? done32 : done)) lat = -1;
        res = sel ? brres32 : brres;
        inv = sel ? brinv32 : brinv;
    endtask

    task automatic test_reset();
        bit seen = 0;
        rst = 1'b1; start = 1'b1; start32 = 1'b1;
        f3 = 3'b000; f3_32 = 3'b000; rd1 = 0; rd2 = 0; rd1_32 = 0; rd2_32 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; start32 = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || done32) seen = 1;
        end
        checks++; if (seen !== 1'b0)  begin failures++; $display("FAIL reset_no_done: got %0b expected 0", seen); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (brres !== 1'b0) begin failures++; $display("FAIL reset_brres: got %0b expected 0", brres); end
        checks++; if (brinv !== 1'b0) begin failures++; $display("FAIL reset_brinv: got %0b expected 0", brinv); end
        checks++; if (busy32 !== 1'b0 || brres32 !== 1'b0) begin failures++; $display("FAIL reset_dut32: got busy=%0b res=%0b expected 0 0", busy32, brres32); end
    endtask

    task automatic test_beq_bne();
        logic [2:0] ops [2] = '{3'b000, 3'b001};
        logic       exp [2] = '{1'b1, 1'b0};
        int lat; logic res, inv;
        for (int i = 0; i < 2; i++) begin
            run_op(0, ops[i], 32'h1234_5678, 32'h1234_5678, lat, res, inv);
            checks++; if (lat !== 5)     begin failures++; $display("FAIL eq_lat f3=%b: got %0d expected 5", ops[i], lat); end
            checks++; if (res !== exp[i]) begin failures++; $display("FAIL eq_res f3=%b: got %0b expected %0b", ops[i], res, exp[i]); end
            checks++; if (inv !== 1'b0)  begin failures++; $display("FAIL eq_inv f3=%b: got %0b expected 0", ops[i], inv); end
        end
    endtask

    task automatic test_early_exit();
        logic [2:0] ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat; logic res, inv;
        for (int i = 0; i < 4; i++) begin
            run_op(0, ops[i], 32'hFFFF_FFFF, 32'h0000_0001, lat, res, inv);
            checks++; if (lat !== 2)      begin failures++; $display("FAIL early_lat f3=%b: got %0d expected 2", ops[i], lat); end
            checks++; if (res !== exp[i]) begin failures++; $display("FAIL early_res f3=%b: got %0b expected %0b", ops[i], res, exp[i]); end
        end
    endtask

    task automatic test_low_slice();
        int lat; logic res, inv;
        run_op(0, 3'b111, 32'h0000_0010, 32'h0000_0011, lat, res, inv);
        checks++; if (lat !== 5)    begin failures++; $display("FAIL low_lat: got %0d expected 5", lat); end
        checks++; if (res !== 1'b0) begin failures++; $display("FAIL low_res: got %0b expected 0", res); end
    endtask

    task automatic test_invalid();
        int lat; logic res, inv;
        run_op(0, 3'b010, 32'h0000_0005, 32'h0000_0005, lat, res, inv);
        checks++; if (lat !== 1)    begin failures++; $display("FAIL inv_lat: got %0d expected 1", lat); end
        checks++; if (res !== 1'b0) begin failures++; $display("FAIL inv_res: got %0b expected 0", res); end
        checks++; if (inv !== 1'b1) begin failures++; $display("FAIL inv_flag: got %0b expected 1", inv); end
        run_op(0, 3'b011, 32'h0000_0000, 32'h0000_0001, lat, res, inv);
        checks++; if (lat !== 1 || inv !== 1'b1) begin failures++; $display("FAIL inv011: got lat=%0d inv=%0b expected 1 1", lat, inv); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0; int first = -1; logic res_at = 1'bx; logic busy_mid = 1'bx;
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'b001; rd1 = 32'h1234_5678; rd2 = 32'h1234_5679;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; res_at = brres; end
            end
            if (c == 2) begin
                busy_mid = busy;
                start = 1'b1; f3 = 3'b000; rd1 = 32'h0; rd2 = 32'h0;
            end
            if (c == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %0b expected 1", busy_mid); end
        checks++; if (ndone !== 1)       begin failures++; $display("FAIL b2b_ndone: got %0d expected 1", ndone); end
        checks++; if (first !== 5)       begin failures++; $display("FAIL b2b_lat: got %0d expected 5", first); end
        checks++; if (res_at !== 1'b1)   begin failures++; $display("FAIL b2b_res: got %0b expected 1", res_at); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0; int lat; logic res, inv;
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'b000; rd1 = 32'h5555_5555; rd2 = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_state: got busy=%0b done=%0b expected 0 0", busy, done); end
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        checks++; if (seen !== 1'b0)  begin failures++; $display("FAIL rstmid_no_done: got %0b expected 0", seen); end
        checks++; if (brres !== 1'b0) begin failures++; $display("FAIL rstmid_brres: got %0b expected 0", brres); end
        run_op(0, 3'b000, 32'hCAFE_0001, 32'hCAFE_0001, lat, res, inv);
        checks++; if (lat !== 5 || res !== 1'b1) begin failures++; $display("FAIL rstmid_fresh: got lat=%0d res=%0b expected 5 1", lat, res); end
    endtask

    task automatic test_chunk_full();
        logic [2:0]  ops [3] = '{3'b100, 3'b111, 3'b000};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [31:0] bs  [3] = '{32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
        logic        exp [3] = '{1'b1, 1'b1, 1'b1};
        int lat; logic res, inv;
        for (int i = 0; i < 3; i++) begin
            run_op(1, ops[i], as[i], bs[i], lat, res, inv);
            checks++; if (lat !== 2)      begin failures++; $display("FAIL c32_lat f3=%b: got %0d expected 2", ops[i], lat); end
            checks++; if (res !== exp[i]) begin failures++; $display("FAIL c32_res f3=%b: got %0b expected %0b", ops[i], res, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_beq_bne();
        test_early_exit();
        test_low_slice();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_chunk_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
